// File: rtl/ptw.sv
// Sv39 hardware page-table walker: services one TLB miss at a time through a
// single-outstanding PTE read port and returns a leaf PTE or a page fault.
module ptw #(
    parameter int unsigned PADDR_W    = 56,
    parameter int unsigned LEVELS     = 3,
    parameter int unsigned LEVEL_BITS = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [3:0]                     i_satp_mode,
    input  logic [43:0]                    i_satp_ppn,
    input  logic                           i_flush,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  logic [LEVELS*LEVEL_BITS-1:0]   i_req_vpn,
    output logic                           o_resp_valid,
    output logic [43:0]                    o_resp_ppn,
    output logic [7:0]                     o_resp_perm,
    output logic [1:0]                     o_resp_level,
    output logic                           o_resp_fault,
    output logic                           o_mem_req_valid,
    input  logic                           i_mem_req_ready,
    output logic [PADDR_W-1:0]             o_mem_req_paddr,
    input  logic                           i_mem_resp_valid,
    input  logic [63:0]                    i_mem_resp_data
);

    localparam int unsigned VPN_W      = LEVELS * LEVEL_BITS;
    localparam int unsigned PPN_W      = 44;
    localparam logic [1:0]  TOP_LEVEL  = 2'(LEVELS - 1);
    localparam logic [3:0]  SATP_SV39  = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t               state_q, state_n;
    logic [VPN_W-1:0]     vpn_q, vpn_n;
    logic [1:0]           level_q, level_n;
    logic [PPN_W-1:0]     base_q, base_n;

    logic                 req_ready_n;
    logic                 mem_req_valid_n;
    logic [PADDR_W-1:0]   paddr_n;
    logic                 resp_valid_n;
    logic [PPN_W-1:0]     resp_ppn_n;
    logic [7:0]           resp_perm_n;
    logic [1:0]           resp_level_n;
    logic                 resp_fault_n;

    logic                 finish;
    logic                 fin_fault;
    logic [1:0]           fin_level;

    // PTE field decode of the incoming read data
    logic [PPN_W-1:0]     pte_ppn;
    logic                 pte_v, pte_r, pte_w, pte_x;
    logic                 pte_bad;
    logic                 pte_leaf;
    logic                 unused_rsw;

    assign pte_ppn    = i_mem_resp_data[53:10];
    assign pte_v      = i_mem_resp_data[0];
    assign pte_r      = i_mem_resp_data[1];
    assign pte_w      = i_mem_resp_data[2];
    assign pte_x      = i_mem_resp_data[3];
    assign pte_bad    = !pte_v || (!pte_r && pte_w) || (|i_mem_resp_data[63:54]);
    assign pte_leaf   = pte_r || pte_x;
    assign unused_rsw = ^i_mem_resp_data[9:8];

    function automatic logic [PADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                                    input logic [VPN_W-1:0] vpn,
                                                    input logic [1:0]       lvl);
        logic [LEVEL_BITS-1:0] idx;
        idx = vpn[32'(lvl) * LEVEL_BITS +: LEVEL_BITS];
        return PADDR_W'({base, 12'h000}) + PADDR_W'({idx, 3'b000});
    endfunction

    // A superpage leaf must have its low PPN bits (below its level) clear
    function automatic logic misaligned(input logic [PPN_W-1:0] ppn, input logic [1:0] lvl);
        logic [PPN_W-1:0] mask;
        mask = (PPN_W'(1) << (32'(lvl) * LEVEL_BITS)) - PPN_W'(1);
        return (ppn & mask) != '0;
    endfunction

    always_comb begin
        state_n         = state_q;
        vpn_n           = vpn_q;
        level_n         = level_q;
        base_n          = base_q;
        mem_req_valid_n = o_mem_req_valid;
        paddr_n         = o_mem_req_paddr;
        resp_valid_n    = 1'b0;
        resp_ppn_n      = o_resp_ppn;
        resp_perm_n     = o_resp_perm;
        resp_level_n    = o_resp_level;
        resp_fault_n    = o_resp_fault;
        finish          = 1'b0;
        fin_fault       = 1'b0;
        fin_level       = level_q;

        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    vpn_n   = i_req_vpn;
                    level_n = TOP_LEVEL;
                    base_n  = i_satp_ppn;
                    if (i_satp_mode == SATP_SV39) begin
                        state_n         = MEM_REQ;
                        mem_req_valid_n = 1'b1;
                        paddr_n         = pte_addr(i_satp_ppn, i_req_vpn, TOP_LEVEL);
                    end else begin
                        finish    = 1'b1;
                        fin_fault = 1'b1;
                        fin_level = TOP_LEVEL;
                    end
                end
            end
            MEM_REQ: begin
                if (i_mem_req_ready) begin
                    mem_req_valid_n = 1'b0;
                    state_n         = i_flush ? DRAIN : MEM_WAIT;
                end else if (i_flush) begin
                    mem_req_valid_n = 1'b0;
                    state_n         = IDLE;
                end
            end
            MEM_WAIT: begin
                // A flush coinciding with the response consumes it, so nothing is left to drain
                if (i_mem_resp_valid) begin
                    if (i_flush) begin
                        state_n = IDLE;
                    end else if (pte_bad) begin
                        finish    = 1'b1;
                        fin_fault = 1'b1;
                    end else if (pte_leaf) begin
                        finish    = 1'b1;
                        fin_fault = misaligned(pte_ppn, level_q);
                    end else if (level_q == 2'd0) begin
                        finish    = 1'b1;
                        fin_fault = 1'b1;
                    end else begin
                        base_n          = pte_ppn;
                        level_n         = level_q - 2'd1;
                        state_n         = MEM_REQ;
                        mem_req_valid_n = 1'b1;
                        paddr_n         = pte_addr(pte_ppn, vpn_q, level_q - 2'd1);
                    end
                end else if (i_flush) begin
                    state_n = DRAIN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            DRAIN: begin
                if (i_mem_resp_valid) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (finish) begin
            state_n      = DONE;
            resp_valid_n = 1'b1;
            resp_fault_n = fin_fault;
            resp_level_n = fin_level;
            resp_ppn_n   = fin_fault ? '0 : pte_ppn;
            resp_perm_n  = fin_fault ? '0 : i_mem_resp_data[7:0];
        end

        req_ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            vpn_q           <= '0;
            level_q         <= '0;
            base_q          <= '0;
            o_req_ready     <= 1'b1;
            o_mem_req_valid <= 1'b0;
            o_mem_req_paddr <= '0;
            o_resp_valid    <= 1'b0;
            o_resp_ppn      <= '0;
            o_resp_perm     <= '0;
            o_resp_level    <= '0;
            o_resp_fault    <= 1'b0;
        end else begin
            state_q         <= state_n;
            vpn_q           <= vpn_n;
            level_q         <= level_n;
            base_q          <= base_n;
            o_req_ready     <= req_ready_n;
            o_mem_req_valid <= mem_req_valid_n;
            o_mem_req_paddr <= paddr_n;
            o_resp_valid    <= resp_valid_n;
            o_resp_ppn      <= resp_ppn_n;
            o_resp_perm     <= resp_perm_n;
            o_resp_level    <= resp_level_n;
            o_resp_fault    <= resp_fault_n;
        end
    end

endmodule

// File: tb/tb_ptw.sv
// Scoreboard bench for the Sv39 page-table walker: directed walks against a
// scripted PTE memory, with responses checked by an independent monitor.
module tb_ptw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  i_satp_mode = 4'd8;
    logic [43:0] i_satp_ppn = 44'h80000;
    logic        i_flush = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [26:0] i_req_vpn = '0;
    logic        o_resp_valid;
    logic [43:0] o_resp_ppn;
    logic [7:0]  o_resp_perm;
    logic [1:0]  o_resp_level;
    logic        o_resp_fault;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b1;
    logic [55:0] o_mem_req_paddr;
    logic        i_mem_resp_valid = 1'b0;
    logic [63:0] i_mem_resp_data = '0;

    ptw dut (
        .clk              (clk),
        .reset            (reset),
        .i_satp_mode      (i_satp_mode),
        .i_satp_ppn       (i_satp_ppn),
        .i_flush          (i_flush),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_vpn        (i_req_vpn),
        .o_resp_valid     (o_resp_valid),
        .o_resp_ppn       (o_resp_ppn),
        .o_resp_perm      (o_resp_perm),
        .o_resp_level     (o_resp_level),
        .o_resp_fault     (o_resp_fault),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_paddr  (o_mem_req_paddr),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_data  (i_mem_resp_data)
    );

    typedef struct {
        logic [43:0] ppn;
        logic [7:0]  perm;
        logic [1:0]  level;
        logic        fault;
        int          lat;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [55:0] paddr;
        logic [63:0] data;
        int          delay;
    } mem_t;

    exp_t        sb[$];
    mem_t        mq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          stall = 0;
    bit          mem_busy = 1'b0;
    bit          have_held = 1'b0;
    logic [55:0] held_paddr = '0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t ok(input logic [43:0] ppn, input logic [7:0] perm,
                                input logic [1:0] lvl, input int lat);
        exp_t e;
        e.ppn = ppn; e.perm = perm; e.level = lvl; e.fault = 1'b0; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t flt(input logic [1:0] lvl, input int lat);
        exp_t e;
        e.ppn = '0; e.perm = '0; e.level = lvl; e.fault = 1'b1; e.lat = lat; e.cyc = 0;
        return e;
    endfunction

    function automatic mem_t m(input logic [55:0] a, input logic [63:0] d, input int dly);
        mem_t e;
        e.paddr = a; e.data = d; e.delay = dly;
        return e;
    endfunction

    task automatic check_reset(input string name);
        chk({name, "_req_ready"},     64'(o_req_ready),     64'd1);
        chk({name, "_resp_valid"},    64'(o_resp_valid),    64'd0);
        chk({name, "_mem_req_valid"}, 64'(o_mem_req_valid), 64'd0);
        chk({name, "_resp_fault"},    64'(o_resp_fault),    64'd0);
        chk({name, "_mem_paddr"},     64'(o_mem_req_paddr), 64'd0);
        chk({name, "_resp_ppn"},      64'(o_resp_ppn),      64'd0);
        chk({name, "_resp_perm"},     64'(o_resp_perm),     64'd0);
        chk({name, "_resp_level"},    64'(o_resp_level),    64'd0);
    endtask

    // Present one miss; the expected result is queued with its required arrival cycle
    task automatic issue(input logic [26:0] vpn, input logic [3:0] mode, input bit want,
                         input exp_t e, input int stall_n);
        @(posedge clk);
        #1;
        i_req_valid = 1'b1;
        i_req_vpn   = vpn;
        i_satp_mode = mode;
        i_satp_ppn  = 44'h80000;
        stall       = stall_n;
        @(negedge clk);
        chk("req_ready_at_issue", 64'(o_req_ready), 64'd1);
        if (want) begin
            e.cyc = cyc + e.lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !o_req_ready || mem_busy || mq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 100) begin
            n_err++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    // Request back-pressure generator
    initial forever begin
        @(posedge clk);
        #2;
        if (stall > 0) begin
            i_mem_req_ready = 1'b0;
            stall--;
        end else begin
            i_mem_req_ready = 1'b1;
        end
    end

    // PTE memory: checks each request address against the script, answers after its delay
    initial begin
        mem_t e;
        forever begin
            @(negedge clk);
            if (!reset && o_mem_req_valid && !i_mem_req_ready) begin
                if (have_held) chk("paddr_stable", 64'(o_mem_req_paddr), 64'(held_paddr));
                held_paddr = o_mem_req_paddr;
                have_held  = 1'b1;
            end else if (!reset && o_mem_req_valid && i_mem_req_ready) begin
                have_held = 1'b0;
                if (mq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_mem_req: paddr 0x%0h, required no request", o_mem_req_paddr);
                    e = m(56'h0, 64'h0, 0);
                end else begin
                    e = mq.pop_front();
                    chk("pte_paddr", 64'(o_mem_req_paddr), 64'(e.paddr));
                end
                mem_busy = 1'b1;
                @(posedge clk);
                repeat (e.delay) @(posedge clk);
                #1;
                i_mem_resp_valid = 1'b1;
                i_mem_resp_data  = e.data;
                @(posedge clk);
                #1;
                i_mem_resp_valid = 1'b0;
                i_mem_resp_data  = '0;
                mem_busy = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && o_resp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: fault=%0d level=%0d ppn=0x%0h, required no response",
                             o_resp_fault, o_resp_level, o_resp_ppn);
                end else begin
                    e = sb.pop_front();
                    chk("resp_fault", 64'(o_resp_fault), 64'(e.fault));
                    chk("resp_level", 64'(o_resp_level), 64'(e.level));
                    chk("resp_ppn",   64'(o_resp_ppn),   64'(e.ppn));
                    chk("resp_perm",  64'(o_resp_perm),  64'(e.perm));
                    chk("resp_cycle", 64'(cyc),          64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #3;
        check_reset("por");
        reset = 1'b0;

        // 4 KiB walk across all three levels
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h20000801, 0));
        mq.push_back(m(56'h80002018, 64'h048D14CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h12345, 8'hCF, 2'd0, 7), 0);
        wait_done("walk4k");

        // Aligned gigapage, then misaligned gigapage
        mq.push_back(m(56'h80000008, 64'h200000CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h80000, 8'hCF, 2'd2, 3), 0);
        wait_done("giga_ok");
        mq.push_back(m(56'h80000008, 64'h200004CF, 0));
        issue(27'h40403, 4'd8, 1'b1, flt(2'd2, 3), 0);
        wait_done("giga_misaligned");

        // Aligned megapage at level 1
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h200800CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h80200, 8'hCF, 2'd1, 5), 0);
        wait_done("mega_ok");

        // Invalid second-level PTE: no third read
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h0, 0));
        issue(27'h40403, 4'd8, 1'b1, flt(2'd1, 5), 0);
        wait_done("invalid_l1");

        // Reserved high bit and W-without-R at the root
        mq.push_back(m(56'h80000008, 64'h00400000200000CF, 0));
        issue(27'h40403, 4'd8, 1'b1, flt(2'd2, 3), 0);
        wait_done("reserved_bits");
        mq.push_back(m(56'h80000008, 64'h20000405, 0));
        issue(27'h40403, 4'd8, 1'b1, flt(2'd2, 3), 0);
        wait_done("w_no_r");

        // Pointer PTE at the last level
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h20000801, 0));
        mq.push_back(m(56'h80002018, 64'h20000C01, 0));
        issue(27'h40403, 4'd8, 1'b1, flt(2'd0, 7), 0);
        wait_done("nonleaf_l0");

        // Back-pressure on the first request
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h20000801, 0));
        mq.push_back(m(56'h80002018, 64'h048D14CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h12345, 8'hCF, 2'd0, 12), 6);
        wait_done("backpressure");

        // Flush in MEM_WAIT with a late response, then a clean walk
        mq.push_back(m(56'h80000008, 64'h200000CF, 3));
        issue(27'h40403, 4'd8, 1'b0, flt(2'd0, 0), 0);
        @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        wait_done("flush_drain");
        mq.push_back(m(56'h80000008, 64'h20000401, 0));
        mq.push_back(m(56'h80001010, 64'h20000801, 0));
        mq.push_back(m(56'h80002018, 64'h048D14CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h12345, 8'hCF, 2'd0, 7), 0);
        wait_done("after_flush");

        // Bare satp mode faults immediately without memory traffic
        issue(27'h40403, 4'd0, 1'b1, flt(2'd2, 1), 0);
        wait_done("satp_bare");

        // Reset mid-walk; the in-flight response arrives while idle
        mq.push_back(m(56'h80000008, 64'h20000401, 4));
        issue(27'h40403, 4'd8, 1'b0, flt(2'd0, 0), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset("mid_walk");
        @(posedge clk);
        #3 reset = 1'b0;
        wait_done("after_reset");
        mq.push_back(m(56'h80000008, 64'h200000CF, 0));
        issue(27'h40403, 4'd8, 1'b1, ok(44'h80000, 8'hCF, 2'd2, 3), 0);
        wait_done("walk_after_reset");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
